// File: rtl/float_argmax_seq.sv
// float_argmax_seq: streams N IEEE-754 scores and reports the index/value of the largest
// under sign-magnitude order (-0 < +0), earliest index winning ties.
module float_argmax_seq #(
    parameter int N     = 10,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [31:0]      out_value,
    output logic             busy
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;
    state_t           r_state;
    logic [IDX_W-1:0] r_count;
    logic [IDX_W-1:0] r_best_idx;
    logic [31:0]      r_best_val;
    logic [31:0]      w_key_in;
    logic [31:0]      w_key_best;
    logic             w_gt;
    logic             w_last;
    // Monotonic key: negatives bit-inverted, positives get the top bit set, so -0 sorts below +0.
    assign w_key_in   = in_data[31]    ? ~in_data    : (in_data    | 32'h8000_0000);
    assign w_key_best = r_best_val[31] ? ~r_best_val : (r_best_val | 32'h8000_0000);
    assign w_gt       = (in_data != r_best_val) && (w_key_in >= w_key_best);
    assign w_last     = r_count == IDX_W'(N - 1);
    assign out_index  = r_best_idx;
    assign out_value  = r_best_val;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_state  <= S_ACCUM;
                    r_count  <= '0;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                end
                S_ACCUM: if (in_valid) begin
                    if (r_count == '0 || w_gt) begin
                        r_best_val <= in_data;
                        r_best_idx <= r_count;
                    end
                    if (w_last) begin
                        r_state   <= S_DONE;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_DONE: if (out_ready) begin
                    r_state   <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_float_argmax_seq.sv
// tb_float_argmax_seq: randomized and directed checks of float_argmax_seq (N=10 and N=1 builds)
// against a value-ordering reference model.
module tb_float_argmax_seq;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_data = 0;
    logic        in_ready, out_valid, busy;
    logic [3:0]  out_index;
    logic [31:0] out_value;
    logic        start1 = 0, in_valid1 = 0, out_ready1 = 0;
    logic [31:0] in_data1 = 0;
    logic        in_ready1, out_valid1, busy1;
    logic [0:0]  out_index1;
    logic [31:0] out_value1;
    int          n_tests = 0, n_fail = 0;
    logic [31:0] vec[10];

    always #5 clk = ~clk;

    float_argmax_seq #(.N(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_value(out_value), .busy(busy));

    float_argmax_seq #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_index(out_index1), .out_value(out_value1), .busy(busy1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // a above b in the float order: positive beats negative, then magnitude (reversed for negatives)
    function automatic bit above(input logic [31:0] a, input logic [31:0] b);
        if (a == b) return 0;
        if (a[31] != b[31]) return b[31];
        return a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
    endfunction

    task automatic model(output int idx, output logic [31:0] val);
        val = vec[0];
        foreach (vec[i]) if (above(vec[i], val)) val = vec[i];
        idx = -1;
        foreach (vec[i]) if (idx < 0 && vec[i] == val) idx = i;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic run_vector(input string tag, input int exp_idx, input logic [31:0] exp_val,
                              input bit gaps, input int stall, input bit poke);
        start = 1;
        tick();
        start = 0;
        chk({tag, " busy"}, busy, 1);
        for (int i = 0; i < 10; i++) begin
            if (gaps) for (int g = 0; g < 4 && $urandom_range(0, 2) == 0; g++) begin
                in_valid = 0;
                start = poke;
                tick();
                start = 0;
            end
            chk({tag, " ready"}, in_ready, 1);
            chk({tag, " early_valid"}, out_valid, 0);
            in_valid = 1;
            in_data  = vec[i];
            tick();
            in_valid = 0;
        end
        chk({tag, " valid"}, out_valid, 1);
        chk({tag, " index"}, out_index, exp_idx);
        chk({tag, " value"}, out_value, exp_val);
        chk({tag, " ready_done"}, in_ready, 0);
        for (int s = 0; s < stall; s++) begin
            start = poke;
            in_valid = 1;
            tick();
            in_valid = 0;
            chk({tag, " stall_valid"}, out_valid, 1);
            chk({tag, " stall_index"}, out_index, exp_idx);
            chk({tag, " stall_value"}, out_value, exp_val);
        end
        out_ready = 1;
        start = poke;
        tick();
        out_ready = 0;
        start = 0;
        chk({tag, " valid_clr"}, out_valid, 0);
        chk({tag, " idle"}, busy, 0);
        tick();
        chk({tag, " stays_idle"}, busy, 0);
    endtask

    initial begin
        int          idx;
        logic [31:0] val;
        #12 rst_n = 0;
        #1;
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst out_index", out_index, 0);
        chk("rst out_value", out_value, 0);
        tick();
        rst_n = 1;
        tick();

        vec = '{32'h3F800000, 32'h40600000, 32'hC0000000, 32'h40E80000, 32'h3F000000,
                32'h40E00000, 32'hC1100000, 32'h40000000, 32'h40DCCCCD, 32'h00000000};
        run_vector("basic", 3, 32'h40E80000, 0, 0, 0);
        run_vector("basic_bp", 3, 32'h40E80000, 1, 5, 1);

        foreach (vec[i]) vec[i] = 32'h3F800000;
        vec[2] = 32'h40800000;
        vec[6] = 32'h40800000;
        run_vector("ties", 2, 32'h40800000, 0, 0, 0);

        vec = '{32'hC0A00000, 32'hBFC00000, 32'hC0400000, 32'hC0800000, 32'hC0C00000,
                32'hC0E00000, 32'hC0200000, 32'hC1200000, 32'hC1100000, 32'hC1000000};
        run_vector("neg", 1, 32'hBFC00000, 0, 0, 0);
        vec[0] = 32'h80000000;
        vec[1] = 32'h00000000;
        run_vector("zeros", 1, 32'h00000000, 0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            logic [31:0] pool[4];
            foreach (pool[k]) pool[k] = $urandom;
            foreach (vec[i]) vec[i] = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            model(idx, val);
            run_vector($sformatf("rand%0d", r), idx, val, r[0], $urandom_range(0, 3), r[1]);
        end

        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            in_data  = 32'h7F000000;
            tick();
        end
        in_valid = 0;
        rst_n = 0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort out_value", out_value, 0);
        chk("abort in_ready", in_ready, 0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort no_valid", out_valid, 0);
        end
        foreach (vec[i]) vec[i] = 32'h3F800000 + i;
        vec[9] = 32'h42000000;
        run_vector("post_rst", 9, 32'h42000000, 1, 2, 0);

        start1 = 1;
        tick();
        start1 = 0;
        chk("n1 ready", in_ready1, 1);
        in_valid1 = 1;
        in_data1  = 32'hC2C80000;
        tick();
        in_valid1 = 0;
        chk("n1 valid", out_valid1, 1);
        chk("n1 index", out_index1, 0);
        chk("n1 value", out_value1, 32'hC2C80000);
        out_ready1 = 1;
        tick();
        out_ready1 = 0;
        chk("n1 valid_clr", out_valid1, 0);
        chk("n1 idle", busy1, 0);
        chk("n2 idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
